tmds_decoder: RTL

TMDS_DECODER -- requirements
Module: tmds_decoder

---
 rtl/tmds_pkg.sv | 34 +++
 rtl/tm_undo.sv | 20 ++
 rtl/tmds_decoder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS control tokens, symbol bit positions and lock FSM states
package tmds_pkg;

   localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

   localparam int INV_BIT = 9;
   localparam int XOR_BIT = 8;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_SLIP   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   function automatic logic is_ctrl(input logic [9:0] sym);
      return (sym == CTRL_TOK_00) || (sym == CTRL_TOK_01) ||
             (sym == CTRL_TOK_10) || (sym == CTRL_TOK_11);
   endfunction

   function automatic logic [1:0] ctrl_val(input logic [9:0] sym);
      logic [1:0] c;
      case (sym)
         CTRL_TOK_01: c = 2'b01;
         CTRL_TOK_10: c = 2'b10;
         CTRL_TOK_11: c = 2'b11;
         default:     c = 2'b00;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/tm_undo.sv
// rtl/tm_undo.sv - combinational TMDS data symbol decode (undo inversion, then undo XOR/XNOR chain)
module tm_undo
   import tmds_pkg::*;
(
   input  logic [9:0] tmds,
   output logic [7:0] data
);

   logic [7:0] d;

   always_comb begin
      d       = tmds[INV_BIT] ? ~tmds[7:0] : tmds[7:0];
      data    = '0;
      data[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         data[i] = tmds[XOR_BIT] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
   end

endmodule

// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - TMDS channel decoder with word-lock search and bitslip requests
// Optional error counter output enabled by defining TMDS_DECODER_ERR_CNT_EN.
module tmds_decoder
   import tmds_pkg::*;
#(
   parameter int LOCK_TOKENS   = 8,
   parameter int SEARCH_CYCLES = 1024,
   parameter int SLIP_WAIT     = 8,
   parameter int LOSS_CYCLES   = 4096
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [9:0]  tmds_in,
   input  logic        valid_in,
   output logic [7:0]  data_out,
   output logic [1:0]  ctrl_out,
   output logic        de_out,
   output logic        valid_out,
   output logic        locked_out,
   output logic        bitslip_out
`ifdef TMDS_DECODER_ERR_CNT_EN
   ,
   output logic [15:0] err_count_out
`endif
);

   localparam int RW = $clog2(LOCK_TOKENS + 1);
   localparam int SW = $clog2(SEARCH_CYCLES + 1);
   localparam int WW = $clog2(SLIP_WAIT + 1);
   localparam int LW = $clog2(LOSS_CYCLES + 1);

   localparam logic [RW-1:0] RUN_MAX    = RW'(LOCK_TOKENS);
   localparam logic [SW-1:0] SEARCH_MAX = SW'(SEARCH_CYCLES);
   localparam logic [WW-1:0] SLIP_MAX   = WW'(SLIP_WAIT);
   localparam logic [LW-1:0] LOSS_MAX   = LW'(LOSS_CYCLES);

   state_t        state;
   logic [RW-1:0] run_cnt;
   logic [SW-1:0] search_cnt;
   logic [WW-1:0] slip_cnt;
   logic [LW-1:0] loss_cnt;

   logic [RW-1:0] run_nxt;
   logic [SW-1:0] search_nxt;
   logic [WW-1:0] slip_nxt;
   logic [LW-1:0] loss_nxt;
   logic [7:0]    dec_data;
   logic          tok;

   tm_undo u_undo (
      .tmds (tmds_in),
      .data (dec_data)
   );

   assign tok = is_ctrl(tmds_in);

   // Saturating increments; the FSM leaves each state before any counter passes its terminal value.
   assign run_nxt    = (run_cnt    == RUN_MAX)    ? run_cnt    : run_cnt    + RW'(1);
   assign search_nxt = (search_cnt == SEARCH_MAX) ? search_cnt : search_cnt + SW'(1);
   assign slip_nxt   = (slip_cnt   == SLIP_MAX)   ? slip_cnt   : slip_cnt   + WW'(1);
   assign loss_nxt   = (loss_cnt   == LOSS_MAX)   ? loss_cnt   : loss_cnt   + LW'(1);

`ifdef TMDS_DECODER_ERR_CNT_EN
   logic sym_err;
   assign sym_err = (tmds_in[9:8] == 2'b01) || ($countones(dec_data) > 8);
`endif

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state       <= ST_SEARCH;
         run_cnt     <= '0;
         search_cnt  <= '0;
         slip_cnt    <= '0;
         loss_cnt    <= '0;
         data_out    <= '0;
         ctrl_out    <= '0;
         de_out      <= 1'b0;
         valid_out   <= 1'b0;
         locked_out  <= 1'b0;
         bitslip_out <= 1'b0;
`ifdef TMDS_DECODER_ERR_CNT_EN
         err_count_out <= '0;
`endif
      end else begin
         valid_out   <= valid_in;
         bitslip_out <= 1'b0;
         if (valid_in) begin
            if (tok) begin
               de_out   <= 1'b0;
               ctrl_out <= ctrl_val(tmds_in);
            end else begin
               de_out   <= 1'b1;
               data_out <= dec_data;
            end

            case (state)
               ST_SEARCH: begin
                  // Lock takes priority over a coincident search timeout.
                  if (tok && (run_nxt == RUN_MAX)) begin
                     state      <= ST_LOCKED;
                     locked_out <= 1'b1;
                     run_cnt    <= '0;
                     search_cnt <= '0;
                     loss_cnt   <= '0;
`ifdef TMDS_DECODER_ERR_CNT_EN
                     err_count_out <= '0;
`endif
                  end else if (search_nxt == SEARCH_MAX) begin
                     state       <= ST_SLIP;
                     bitslip_out <= 1'b1;
                     run_cnt     <= '0;
                     search_cnt  <= '0;
                     slip_cnt    <= '0;
                  end else begin
                     run_cnt    <= tok ? run_nxt : '0;
                     search_cnt <= search_nxt;
                  end
               end

               ST_SLIP: begin
                  if (slip_nxt == SLIP_MAX) begin
                     state      <= ST_SEARCH;
                     slip_cnt   <= '0;
                     run_cnt    <= '0;
                     search_cnt <= '0;
                  end else begin
                     slip_cnt <= slip_nxt;
                  end
               end

               ST_LOCKED: begin
                  if (tok) begin
                     loss_cnt <= '0;
                  end else if (loss_nxt == LOSS_MAX) begin
                     state      <= ST_SEARCH;
                     locked_out <= 1'b0;
                     loss_cnt   <= '0;
                     run_cnt    <= '0;
                     search_cnt <= '0;
                  end else begin
                     loss_cnt <= loss_nxt;
                  end
`ifdef TMDS_DECODER_ERR_CNT_EN
                  if (!tok && sym_err && (err_count_out != 16'hFFFF)) begin
                     err_count_out <= err_count_out + 16'd1;
                  end
`endif
               end

               default: state <= ST_SEARCH;
            endcase
         end
      end
   end

endmodule
